// File: rtl/coef_store_pkg.sv
// Shared command/state encodings and the width helper for the coefficient vector store.
package coef_store_pkg;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_STREAM  = 2'b01,
      OP_CLEAR   = 2'b10,
      OP_ILLEGAL = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN
   } state_e;

   // Ceiling log2, never below 1 so single-entry configurations keep a legal port width.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/coef_ram_2d.sv
// Simple dual-port RAM holding every coefficient vector in one flat array.
// Flat address = vector*(max_degree+1)+coef; read data appears one cycle after re.
module coef_ram_2d
   import coef_store_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int num_vectors = 8,
   parameter int max_degree  = 10,
   localparam int DEPTH      = num_vectors * (max_degree + 1),
   localparam int AW         = clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [word_size-1:0] wdata,
   input  logic                 re,
   input  logic [AW-1:0]        raddr,
   output logic [word_size-1:0] rdata
);

   logic [word_size-1:0] mem_q [DEPTH];
   logic [word_size-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/coef_vector_store.sv
// Command-driven coefficient vector store: whole-vector LOAD, highest-degree-first STREAM.
// Define COEF_VECTOR_CLEAR_EN to enable the CLEAR command (op 10); otherwise op 10 is rejected.
module coef_vector_store
   import coef_store_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int num_vectors = 8,
   parameter int max_degree  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [clog2(num_vectors)-1:0] cmd_vector,
   input  logic [clog2(max_degree):0]    cmd_degree,
   input  logic [word_size-1:0]          wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic [word_size-1:0]          rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic                          rd_last,
   output logic [clog2(max_degree):0]    rd_degree,
   output logic                          err
);

   localparam int VW = clog2(num_vectors);
   localparam int DW = clog2(max_degree) + 1;
   localparam int AW = clog2(num_vectors * (max_degree + 1));
   localparam logic [DW-1:0] MAX_DEG = DW'(max_degree);

   state_e                 state_q, state_d;
   logic [VW-1:0]          vec_q, vec_d;
   logic [DW-1:0]          deg_q, deg_d;
   logic [DW-1:0]          cnt_q, cnt_d;
   logic [num_vectors-1:0] valid_q, valid_d;
   logic [DW-1:0]          degree_q [num_vectors];
   logic [DW-1:0]          degree_d [num_vectors];
   logic [DW-1:0]          rd_degree_q, rd_degree_d;
   logic                   err_q, err_d;
   logic                   pend_q, pend_d;
   logic                   pend_last_q, pend_last_d;
   logic [1:0]             occ_q, occ_d;
   logic                   wptr_q, wptr_d;
   logic                   rptr_q, rptr_d;
   logic [1:0]             last_q, last_d;
   logic [word_size-1:0]   buf_q [2];
   logic [word_size-1:0]   buf_d [2];

   logic                   ram_we, ram_re;
   logic [AW-1:0]          ram_waddr, ram_raddr;
   logic [word_size-1:0]   ram_rdata;
   logic [DW-1:0]          sel_deg;
   logic [1:0]             fill;
   logic                   pop, room;

   function automatic logic [AW-1:0] flat_addr(input logic [VW-1:0] v, input logic [DW-1:0] c);
      return AW'(v) * AW'(max_degree + 1) + AW'(c);
   endfunction

   assign cmd_ready = (state_q == ST_IDLE);
   assign wr_ready  = (state_q == ST_LOAD);
   assign rd_valid  = (occ_q != 2'd0);
   assign rd_data   = rd_valid ? buf_q[rptr_q] : '0;
   assign rd_last   = rd_valid & last_q[rptr_q];
   assign rd_degree = rd_degree_q;
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      deg_d       = deg_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      degree_d    = degree_q;
      rd_degree_d = rd_degree_q;
      err_d       = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_waddr   = flat_addr(vec_q, cnt_q);
      ram_raddr   = flat_addr(vec_q, cnt_q);
      sel_deg     = degree_q[cmd_vector];
      pop         = rd_valid && rd_ready;
      // Occupancy after this edge, counting the read already in flight; a new read needs a free slot.
      fill        = occ_q + {1'b0, pend_q} - {1'b0, pop};
      room        = (fill < 2'd2);

      buf_d  = buf_q;
      last_d = last_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = fill;
      if (pend_q) begin
         buf_d[wptr_q]  = ram_rdata;
         last_d[wptr_q] = pend_last_q;
         wptr_d         = ~wptr_q;
      end
      if (pop) rptr_d = ~rptr_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_LOAD: begin
                     if (cmd_degree > MAX_DEG) begin
                        err_d = 1'b1;
                     end else begin
                        vec_d               = cmd_vector;
                        deg_d               = cmd_degree;
                        cnt_d               = '0;
                        valid_d[cmd_vector] = 1'b0;
                        state_d             = ST_LOAD;
                     end
                  end
                  OP_STREAM: begin
                     if (!valid_q[cmd_vector]) begin
                        err_d = 1'b1;
                     end else begin
                        // The top coefficient is read in the accept cycle to meet the 2-cycle first-word latency.
                        vec_d       = cmd_vector;
                        rd_degree_d = sel_deg;
                        ram_re      = 1'b1;
                        ram_raddr   = flat_addr(cmd_vector, sel_deg);
                        pend_d      = 1'b1;
                        pend_last_d = (sel_deg == '0);
                        cnt_d       = sel_deg - 1'b1;
                        state_d     = (sel_deg == '0) ? ST_DRAIN : ST_STREAM;
                     end
                  end
                  OP_CLEAR: begin
`ifdef COEF_VECTOR_CLEAR_EN
                     valid_d[cmd_vector]  = 1'b0;
                     degree_d[cmd_vector] = '0;
`else
                     err_d = 1'b1;
`endif
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_LOAD: begin
            if (wr_valid) begin
               ram_we = 1'b1;
               if (cnt_q == deg_q) begin
                  valid_d[vec_q]  = 1'b1;
                  degree_d[vec_q] = deg_q;
                  state_d         = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (room) begin
               ram_re      = 1'b1;
               pend_d      = 1'b1;
               pend_last_d = (cnt_q == '0);
               if (cnt_q == '0) state_d = ST_DRAIN;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         ST_DRAIN: begin
            if (pop && rd_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vec_q       <= '0;
         deg_q       <= '0;
         cnt_q       <= '0;
         valid_q     <= '0;
         degree_q    <= '{default: '0};
         rd_degree_q <= '0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         occ_q       <= '0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         deg_q       <= deg_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         degree_q    <= degree_d;
         rd_degree_q <= rd_degree_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         occ_q       <= occ_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         last_q      <= last_d;
      end
   end

   // Output buffer payload carries no reset; rd_data is masked by rd_valid instead.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   coef_ram_2d #(
      .word_size   (word_size),
      .num_vectors (num_vectors),
      .max_degree  (max_degree)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

endmodule
